// File: rtl/mem_decoder_mr_pkg.sv
// Shared types for the multi-region data-path decoder: size/cause codes, FSM states,
// default region map and the byte-enable helper.
package mem_decoder_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_UNMAPPED = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_BADSIZE  = 2'd3
  } cause_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MMIO_WAIT = 2'd1,
    ST_DONE      = 2'd2
  } state_t;

  localparam logic [31:0] DEF_GLOBAL_BASE  = 32'h1001_0000;
  localparam int          DEF_GLOBAL_WORDS = 1024;
  localparam logic [31:0] DEF_STACK_BASE   = 32'h7FFF_EFFC;
  localparam int          DEF_STACK_WORDS  = 1024;
  localparam logic [31:0] DEF_MMIO_BASE    = 32'hFFFF_0000;
  localparam int          DEF_MMIO_WORDS   = 4;

  // Little-endian lane mask; misaligned sizes never reach here.
  function automatic logic [3:0] beFor(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_decoder_mr_if.sv
// Load/store request, RAM/MMIO strobes, response and sticky-fault signals of the decoder.
// master = load/store stage side, slave = decoder side.
interface mem_decoder_mr_if #(
  parameter int PADDR_W = 11,
  parameter int MMIO_AW = 2
);
  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_addr;
  logic               req_write;
  logic [1:0]         req_size;
  logic [PADDR_W-1:0] ram_addr;
  logic               ram_en;
  logic               ram_we;
  logic [3:0]         ram_be;
  logic [MMIO_AW-1:0] mmio_addr;
  logic               mmio_en;
  logic               mmio_we;
  logic               resp_valid;
  logic               resp_fault;
  logic               fault;
  logic [1:0]         fault_cause;
  logic [31:0]        bad_vaddr;
  logic               fault_clr;

  modport master (
    output req_valid, req_addr, req_write, req_size, fault_clr,
    input  req_ready, ram_addr, ram_en, ram_we, ram_be, mmio_addr, mmio_en, mmio_we,
           resp_valid, resp_fault, fault, fault_cause, bad_vaddr
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_size, fault_clr,
    output req_ready, ram_addr, ram_en, ram_we, ram_be, mmio_addr, mmio_en, mmio_we,
           resp_valid, resp_fault, fault, fault_cause, bad_vaddr
  );
endinterface

// File: rtl/mem_decoder_mr_region_match.sv
// Half-open [BASE, BASE+4*WORDS) range check with word offset; purely combinational,
// zero latency, no backpressure.
module mem_region_match #(
  parameter logic [31:0] BASE  = 32'h0,
  parameter int unsigned WORDS = 1
) (
  input  logic [31:0] addr,
  output logic        hit,
  output logic [31:0] woff
);
  localparam logic [31:0] SPAN = 32'(WORDS) << 2;

  logic [31:0] diff;

  // Unsigned compare on the difference avoids overflow of BASE+SPAN.
  assign diff = addr - BASE;
  assign hit  = (addr >= BASE) && (diff < SPAN);
  assign woff = diff >> 2;
endmodule

// File: rtl/mem_decoder_mr.sv
// Registered virtual-to-physical decoder: RAM/fault respond 1 cycle after accept, MMIO after
// 1+MMIO_WAIT; one access outstanding, req_ready low from accept until the response cycle ends.
module mem_decoder_mr
  import mem_decoder_pkg::*;
#(
  parameter int          PADDR_W      = 11,
  parameter logic [31:0] GLOBAL_BASE  = DEF_GLOBAL_BASE,
  parameter int          GLOBAL_WORDS = DEF_GLOBAL_WORDS,
  parameter logic [31:0] STACK_BASE   = DEF_STACK_BASE,
  parameter int          STACK_WORDS  = DEF_STACK_WORDS,
  parameter logic [31:0] MMIO_BASE    = DEF_MMIO_BASE,
  parameter int          MMIO_WORDS   = DEF_MMIO_WORDS,
  parameter int          MMIO_AW      = 2,
  parameter int          MMIO_WAIT    = 2
) (
  input logic            clk,
  input logic            rst,
  mem_decoder_mr_if.slave bus
);
  localparam int WAIT_W = (MMIO_WAIT > 0) ? $clog2(MMIO_WAIT + 1) : 1;

  state_t state, stateNext;
  logic gHit, sHit, mHit;
  logic [31:0] gOff, sOff, mOff;
  logic accept, isMmio;
  cause_t cause;
  logic [PADDR_W-1:0] ramIdx;

  logic               accFault, accWe;
  logic [PADDR_W-1:0] accAddr;
  logic [3:0]         accBe;
  logic [MMIO_AW-1:0] accMmio;
  logic [WAIT_W-1:0]  waitCnt;
  logic               faultQ;
  cause_t             causeQ;
  logic [31:0]        badQ;
  logic ramEn, mmioEn, respValid, respFault;

  mem_region_match #(.BASE(GLOBAL_BASE), .WORDS(GLOBAL_WORDS)) uGlobal (
    .addr(bus.req_addr), .hit(gHit), .woff(gOff));
  mem_region_match #(.BASE(STACK_BASE), .WORDS(STACK_WORDS)) uStack (
    .addr(bus.req_addr), .hit(sHit), .woff(sOff));
  mem_region_match #(.BASE(MMIO_BASE), .WORDS(MMIO_WORDS)) uMmio (
    .addr(bus.req_addr), .hit(mHit), .woff(mOff));

  assign accept = bus.req_valid && (state == ST_IDLE);
  assign isMmio = (cause == CAUSE_NONE) && mHit && !gHit && !sHit;

  always_comb begin
    cause = CAUSE_NONE;
    if (bus.req_size == SZ_RSVD)
      cause = CAUSE_BADSIZE;
    else if ((bus.req_size == SZ_HALF && bus.req_addr[0]) ||
             (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00))
      cause = CAUSE_MISALIGN;
    else if (!(gHit || sHit || mHit))
      cause = CAUSE_UNMAPPED;
    ramIdx = gHit ? PADDR_W'(gOff) : PADDR_W'(32'(GLOBAL_WORDS) + sOff);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    ramEn     = 1'b0;
    mmioEn    = 1'b0;
    respValid = 1'b0;
    respFault = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) stateNext = isMmio ? ST_MMIO_WAIT : ST_DONE;
      end
      ST_MMIO_WAIT: begin
        mmioEn = 1'b1;
        if (waitCnt == '0) begin
          respValid = 1'b1;
          stateNext = ST_IDLE;
        end
      end
      ST_DONE: begin
        ramEn     = !accFault;
        respValid = 1'b1;
        respFault = accFault;
        stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accFault <= 1'b0;
      accWe    <= 1'b0;
      accAddr  <= '0;
      accBe    <= '0;
      accMmio  <= '0;
      waitCnt  <= '0;
    end else if (accept) begin
      accFault <= (cause != CAUSE_NONE);
      accWe    <= bus.req_write;
      accAddr  <= ramIdx;
      accBe    <= beFor(bus.req_size, bus.req_addr[1:0]);
      accMmio  <= MMIO_AW'(mOff);
      waitCnt  <= WAIT_W'(MMIO_WAIT);
    end else if (state == ST_MMIO_WAIT && waitCnt != '0) begin
      waitCnt <= waitCnt - 1'b1;
    end
  end

  // A clear issued together with a new fault lets the new fault be captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      faultQ <= 1'b0;
      causeQ <= CAUSE_NONE;
      badQ   <= '0;
    end else if (accept && cause != CAUSE_NONE && (!faultQ || bus.fault_clr)) begin
      faultQ <= 1'b1;
      causeQ <= cause;
      badQ   <= bus.req_addr;
    end else if (bus.fault_clr) begin
      faultQ <= 1'b0;
      causeQ <= CAUSE_NONE;
      badQ   <= '0;
    end
  end

  assign bus.req_ready   = (state == ST_IDLE);
  assign bus.ram_en      = ramEn;
  assign bus.ram_we      = ramEn && accWe;
  assign bus.ram_addr    = ramEn ? accAddr : '0;
  assign bus.ram_be      = ramEn ? accBe : '0;
  assign bus.mmio_en     = mmioEn;
  assign bus.mmio_we     = mmioEn && accWe;
  assign bus.mmio_addr   = mmioEn ? accMmio : '0;
  assign bus.resp_valid  = respValid;
  assign bus.resp_fault  = respFault;
  assign bus.fault       = faultQ;
  assign bus.fault_cause = causeQ;
  assign bus.bad_vaddr   = badQ;
endmodule

// File: tb/tb_mem_decoder_mr.sv
// Directed bench for mem_decoder_mr: expected responses queued at request time and
// checked when resp_valid appears.
module tb_mem_decoder_mr;
  import mem_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_decoder_mr_if #(.PADDR_W(11), .MMIO_AW(2)) bus ();

  mem_decoder_mr #(.PADDR_W(11), .MMIO_AW(2), .MMIO_WAIT(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        ramEn;
    logic        we;
    logic [10:0] addr;
    logic [3:0]  be;
    logic        mmioEn;
    logic [1:0]  mAddr;
    logic        flt;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ramExp(input logic we, input logic [10:0] addr, input logic [3:0] be);
    exp_t e;
    e = '{ramEn: 1'b1, we: we, addr: addr, be: be, mmioEn: 1'b0, mAddr: 2'd0, flt: 1'b0, cyc: 1};
    return e;
  endfunction

  function automatic exp_t faultExp();
    exp_t e;
    e = '{ramEn: 1'b0, we: 1'b0, addr: 11'd0, be: 4'd0, mmioEn: 1'b0, mAddr: 2'd0, flt: 1'b1, cyc: 1};
    return e;
  endfunction

  function automatic exp_t mmioExp(input logic we, input logic [1:0] ma, input int waitCycles);
    exp_t e;
    e = '{ramEn: 1'b0, we: we, addr: 11'd0, be: 4'd0, mmioEn: 1'b1, mAddr: ma, flt: 1'b0,
          cyc: waitCycles + 1};
    return e;
  endfunction

  task automatic access(input logic [31:0] a, input logic w, input logic [1:0] sz, input exp_t e);
    exp_t got;
    int cyc, mCyc, readyHigh;
    sb.push_back(e);
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    chk("resp_pulse_low", bus.resp_valid, 0);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_write = w;
    bus.req_size  = sz;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd0;
    cyc = 1; mCyc = 0; readyHigh = 0;
    while (!bus.resp_valid && cyc < 20) begin
      if (bus.mmio_en) mCyc++;
      if (bus.req_ready) readyHigh++;
      @(negedge clk);
      cyc++;
    end
    if (bus.mmio_en) mCyc++;
    if (bus.req_ready) readyHigh++;
    got = sb.pop_front();
    chk($sformatf("resp_valid@%h", a), bus.resp_valid, 1);
    chk($sformatf("latency@%h", a), cyc, got.cyc);
    chk($sformatf("resp_fault@%h", a), bus.resp_fault, got.flt);
    chk($sformatf("ram_en@%h", a), bus.ram_en, got.ramEn);
    chk($sformatf("ram_we@%h", a), bus.ram_we, got.ramEn & got.we);
    chk($sformatf("ram_addr@%h", a), bus.ram_addr, got.addr);
    chk($sformatf("ram_be@%h", a), bus.ram_be, got.be);
    chk($sformatf("mmio_en@%h", a), bus.mmio_en, got.mmioEn);
    chk($sformatf("mmio_we@%h", a), bus.mmio_we, got.mmioEn & got.we);
    chk($sformatf("mmio_addr@%h", a), bus.mmio_addr, got.mAddr);
    chk($sformatf("mmio_cycles@%h", a), mCyc, got.mmioEn ? got.cyc : 0);
    chk($sformatf("ready_low@%h", a), readyHigh, 0);
  endtask

  task automatic checkFault(input logic [1:0] cause, input logic [31:0] bad);
    chk("fault", bus.fault, 1);
    chk("fault_cause", bus.fault_cause, cause);
    chk("bad_vaddr", bus.bad_vaddr, bad);
  endtask

  task automatic clearFault();
    @(negedge clk);
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    chk("clr_fault", bus.fault, 0);
    chk("clr_cause", bus.fault_cause, 0);
    chk("clr_bad_vaddr", bus.bad_vaddr, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd0;
    bus.fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_mmio_en", bus.mmio_en, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_cause", bus.fault_cause, 0);
    chk("rst_bad_vaddr", bus.bad_vaddr, 0);
    rst = 1'b0;

    // Main function: RAM global/stack, MMIO with waits.
    access(32'h1001_0008, 1'b0, SZ_WORD, ramExp(1'b0, 11'd2, 4'b1111));
    access(32'h7FFF_F003, 1'b1, SZ_BYTE, ramExp(1'b1, 11'h401, 4'b1000));
    access(32'hFFFF_0004, 1'b1, SZ_WORD, mmioExp(1'b1, 2'd1, 2));
    access(32'h1001_0006, 1'b1, SZ_HALF, ramExp(1'b1, 11'd1, 4'b1100));
    access(32'h1001_0001, 1'b0, SZ_BYTE, ramExp(1'b0, 11'd0, 4'b0010));

    // Sticky fault keeps the first capture.
    access(32'h1001_0001, 1'b0, SZ_HALF, faultExp());
    checkFault(CAUSE_MISALIGN, 32'h1001_0001);
    access(32'h0000_0000, 1'b0, SZ_WORD, faultExp());
    checkFault(CAUSE_MISALIGN, 32'h1001_0001);
    clearFault();

    // Region boundaries.
    access(32'h1001_0FFC, 1'b0, SZ_WORD, ramExp(1'b0, 11'h3FF, 4'b1111));
    access(32'h1001_1000, 1'b0, SZ_WORD, faultExp());
    checkFault(CAUSE_UNMAPPED, 32'h1001_1000);
    clearFault();
    access(32'h7FFF_EFFC, 1'b0, SZ_WORD, ramExp(1'b0, 11'h400, 4'b1111));
    access(32'h7FFF_FFFC, 1'b0, SZ_WORD, faultExp());
    checkFault(CAUSE_UNMAPPED, 32'h7FFF_FFFC);
    clearFault();
    access(32'h1001_0000, 1'b0, SZ_RSVD, faultExp());
    checkFault(CAUSE_BADSIZE, 32'h1001_0000);
    access(32'hFFFF_000C, 1'b0, SZ_WORD, mmioExp(1'b0, 2'd3, 2));

    // Reset in the middle of an MMIO access drops it silently.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hFFFF_0008;
    bus.req_write = 1'b1;
    bus.req_size  = SZ_WORD;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mmio_before_rst", bus.mmio_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_mmio_en", bus.mmio_en, 0);
    chk("rst_mid_resp_valid", bus.resp_valid, 0);
    chk("rst_mid_req_ready", bus.req_ready, 1);
    chk("rst_mid_fault", bus.fault, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("no_resp_after_rst_%0d", i), bus.resp_valid, 0);
    end
    access(32'h1001_0010, 1'b1, SZ_WORD, ramExp(1'b1, 11'd4, 4'b1111));
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
